// File: rtl/addsub_arbiter.sv
// Round-robin controller sharing one external adder-subtractor among four requesters.
// Each transaction is IDLE -> EXEC -> RESP, with operands latched at grant time.
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [3:0]         sub_in,
    input  logic [4*WIDTH-1:0] a_in,
    input  logic [4*WIDTH-1:0] b_in,
    output logic [3:0]         grant,
    output logic [WIDTH-1:0]   as_a,
    output logic [WIDTH-1:0]   as_b,
    output logic               as_sub,
    input  logic [WIDTH-1:0]   as_sum,
    input  logic               as_cout,
    input  logic               as_ovf,
    output logic [WIDTH-1:0]   result,
    output logic               cout,
    output logic               ovf,
    output logic               done,
    output logic [1:0]         done_id,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       win_q, win_d;
    logic [WIDTH-1:0] as_a_q, as_a_d;
    logic [WIDTH-1:0] as_b_q, as_b_d;
    logic             as_sub_q, as_sub_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       done_id_q, done_id_d;

    logic [WIDTH-1:0] a_slot [4];
    logic [WIDTH-1:0] b_slot [4];
    logic             pick_found;
    logic [1:0]       pick_idx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_slot[i] = a_in[i*WIDTH +: WIDTH];
            b_slot[i] = b_in[i*WIDTH +: WIDTH];
        end
    end

    // Scan from ptr upward (mod 4); the first pending request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!pick_found && req[ptr_q + 2'(i)]) begin
                pick_found = 1'b1;
                pick_idx   = ptr_q + 2'(i);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            win_q     <= 2'd0;
            as_a_q    <= '0;
            as_b_q    <= '0;
            as_sub_q  <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_id_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            as_a_q    <= as_a_d;
            as_b_q    <= as_b_d;
            as_sub_q  <= as_sub_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            done_id_q <= done_id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every comb output gets a hold default first so no latch is inferred.
    always_comb begin
        ptr_d     = ptr_q;
        win_d     = win_q;
        as_a_d    = as_a_q;
        as_b_d    = as_b_q;
        as_sub_d  = as_sub_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        done_id_d = done_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    win_d    = pick_idx;
                    as_a_d   = a_slot[pick_idx];
                    as_b_d   = b_slot[pick_idx];
                    as_sub_d = sub_in[pick_idx];
                end
            end
            EXEC: begin
                result_d  = as_sum;
                cout_d    = as_cout;
                ovf_d     = as_ovf;
                done_id_d = win_q;
            end
            RESP: begin
                // The winner drops to lowest priority for the next scan.
                ptr_d = win_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        grant = (state_q != IDLE) ? (4'b0001 << win_q) : 4'b0000;
        busy  = (state_q != IDLE);
        done  = (state_q == RESP);
    end

    assign as_a    = as_a_q;
    assign as_b    = as_b_q;
    assign as_sub  = as_sub_q;
    assign result  = result_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign done_id = done_id_q;

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin controller that shares one adder-subtractor unit among four requesters in the 6_adder_subtractor design. It picks one pending request, drives the shared unit's operands and mode, captures the sum and flags, and returns them to the winner with a one-cycle `done` pulse. The grant is a one-hot 2-to-4 decode of the winning index.

## Interface
- `WIDTH`, 8, operand/result width in bits.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request per requester; held high until its `done`.
- `sub_in`  in  4  per-requester mode: 1 = subtract (a-b), 0 = add.
- `a_in`  in  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `b_in`  in  4*WIDTH  operand B, same packing.
- `grant`  out  4  one-hot winner, high during EXEC and RESP.
- `as_a`  out  WIDTH  operand A to the shared unit.
- `as_b`  out  WIDTH  operand B to the shared unit.
- `as_sub`  out  1  mode to the shared unit.
- `as_sum`  in  WIDTH  combinational result from the shared unit.
- `as_cout`  in  1  carry-out from the shared unit.
- `as_ovf`  in  1  signed overflow from the shared unit.
- `result`  out  WIDTH  captured `as_sum`, valid while `done`=1.
- `cout`  out  1  captured `as_cout`, valid while `done`=1.
- `ovf`  out  1  captured `as_ovf`, valid while `done`=1.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  2  index of the completed requester, valid while `done`=1.
- `busy`  out  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- IDLE with `req`==0: stay in IDLE.
- IDLE with `req`!=0: choose winner w. Register `as_a`/`as_b`/`as_sub` from slot w, set `grant`=1<<w, go to EXEC.
- EXEC: the shared unit settles. At the clock edge, capture `as_sum`/`as_cout`/`as_ovf` into `result`/`cout`/`ovf`, set `done_id`=w, go to RESP.
- RESP: `done`=1 for exactly this cycle. At the edge, clear `grant`, set `ptr`=(w+1) mod 4 (3 wraps to 0), go to IDLE.
- Arbitration: 2-bit pointer `ptr`, reset 0. Scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first with `req` high wins.
- Requests are sampled only in IDLE. `req`/operand changes during EXEC or RESP are ignored, because operands are latched.
- Dropping `req` mid-operation does not abort it; `done` still pulses.
- A winner whose `req` stays high after `done` is eligible again, but at lowest priority.
- `as_*`, `result`, `cout`, `ovf`, `done_id` hold their last values in IDLE.
- Arithmetic belongs to the shared unit: `as_sum` = (as_a + (as_sub ? ~as_b : as_b) + as_sub) mod 2^WIDTH. The controller only registers the outputs.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `done_id`=0, `result`=0, `cout`=0, `ovf`=0, `as_a`=0, `as_b`=0, `as_sub`=0; state IDLE; `ptr`=0.
- `rst` high at an edge overrides all other activity, including mid-EXEC or mid-RESP. An aborted operation produces no `done`.
- Cycle timing, with edge k sampling a request in IDLE:
  - after edge k: `grant`/`busy` high, state EXEC;
  - after edge k+1: `done` high, state RESP;
  - after edge k+2: `grant`/`done`/`busy` low, state IDLE.
- Transaction length 3 cycles; no idle cycle needed before the next grant. Peak throughput is one operation per 3 cycles.
- Shared-unit combinational path: `as_*` register -> unit -> `result` register, one full cycle.
- `grant` is always one-hot or zero, never multi-hot.

## Test plan
- Reset then single add: req=0001, a0=8'd25, b0=8'd17, sub0=0 -> grant=0001 one cycle later; done one cycle after that with result=42, cout=0, ovf=0, done_id=0.
- Subtract with overflow: req=0100, a2=8'h80, b2=8'h01, sub2=1 -> result=8'h7F, ovf=1, cout=1, done_id=2.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; exactly one done per 3 cycles; done_id sequence 0,1,2,3,0.
- Pointer wrap: grant 3 first (req=1000), then req=1001 -> next winner is 0, not 3.
- Requester 1 drops req during EXEC -> done still pulses with done_id=1; the operation is not repeated.
- rst asserted during EXEC -> next cycle grant=0, busy=0, done never pulses; a following req=0010 wins at pointer 0 scan order (winner 1).
